// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder: one GROUP-lookahead slice per stage, latency PIPE_STAGES cycles.
// Backpressure: the whole pipe advances only when out_ready | ~out_valid. in_ready mirrors that.
// Optional signed-overflow output ovf when CLA_OVF_EN is defined.
module cla_pipe_adder #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2,
    parameter int GROUP       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef CLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int PS = (PIPE_STAGES < 1) ? 1 : PIPE_STAGES;
    localparam int GP = (GROUP < 1) ? 1 : GROUP;
    localparam int S  = WIDTH / PS;

    if (PIPE_STAGES < 1 || (WIDTH % (PS * GP)) != 0) begin : g_bad_cfg
        $fatal(1, "cla_pipe_adder: WIDTH must be a multiple of PIPE_STAGES*GROUP, PIPE_STAGES >= 1");
    end

    // Bit carries ripple inside a group; the carry into the next group comes from group G/P.
    function automatic logic [S:0] slice_add(input logic [S-1:0] x,
                                             input logic [S-1:0] y,
                                             input logic         cin);
        logic [S-1:0] g;
        logic [S-1:0] p;
        logic [S:0]   c;
        logic         gg;
        logic         pp;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = cin;
        for (int j = 0; j < S / GP; j++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int i = 0; i < GP; i++) begin
                c[j*GP+i+1] = g[j*GP+i] | (p[j*GP+i] & c[j*GP+i]);
                gg          = g[j*GP+i] | (p[j*GP+i] & gg);
                pp          = pp & p[j*GP+i];
            end
            c[(j+1)*GP] = gg | (pp & c[j*GP]);
        end
        return {c[S], p ^ c[S-1:0]};
    endfunction

    logic adv;
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        // ua/ub hold the not-yet-added slices k..top; s_n the finished slices 0..k.
        localparam int UW = (PIPE_STAGES - k) * S;
        logic [UW-1:0]        ua;
        logic [UW-1:0]        ub;
        logic                 cy;
        logic                 vl;
        logic [S:0]           r;
        logic [(k+1)*S-1:0]   s_n;
        logic [(k+1)*S-1:0]   s_q;
        logic                 c_q;
        logic                 v_q;

        assign r = slice_add(ua[S-1:0], ub[S-1:0], cy);

        if (k == 0) begin : g_src
            assign ua  = a;
            assign ub  = b;
            assign cy  = c_in;
            assign vl  = in_valid;
            assign s_n = r[S-1:0];
        end else begin : g_src
            assign ua  = g_stage[k-1].g_skew.a_q;
            assign ub  = g_stage[k-1].g_skew.b_q;
            assign cy  = g_stage[k-1].c_q;
            assign vl  = g_stage[k-1].v_q;
            assign s_n = {r[S-1:0], g_stage[k-1].s_q};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= vl;
                c_q <= r[S];
                s_q <= s_n;
            end
        end

        if (k < PIPE_STAGES - 1) begin : g_skew
            logic [UW-S-1:0] a_q;
            logic [UW-S-1:0] b_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= ua[UW-1:S];
                    b_q <= ub[UW-1:S];
                end
            end
        end

        if (k == PIPE_STAGES - 1) begin : g_last
`ifdef CLA_OVF_EN
            // The operand MSBs reach this stage through the skew registers, so ovf stays aligned.
            logic ovf_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= (ua[S-1] == ub[S-1]) & (r[S-1] != ua[S-1]);
                end
            end
`endif
        end
    end

    assign out_valid = g_stage[PIPE_STAGES-1].v_q;
    assign sum       = g_stage[PIPE_STAGES-1].s_q;
    assign c_out     = g_stage[PIPE_STAGES-1].c_q;
`ifdef CLA_OVF_EN
    assign ovf       = g_stage[PIPE_STAGES-1].g_last.ovf_q;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder (WIDTH=32, PIPE_STAGES=2, GROUP=4); ovf checked with CLA_OVF_EN.
module tb_cla_pipe_adder;

    localparam int W = 32;
    localparam int P = 2;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
`ifdef CLA_OVF_EN
    logic         ovf;
`endif

    cla_pipe_adder #(.WIDTH(W), .PIPE_STAGES(P), .GROUP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out)
`ifdef CLA_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [W+1:0] exp_q[$];
    int           out_cyc[$];
    logic         rnd_done;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W+1:0] mk(input logic co, input logic [W-1:0] s, input logic ov);
        return {ov, co, s};
    endfunction

    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        logic [W:0] t;
        t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        return {(x[W-1] == y[W-1]) && (t[W-1] != x[W-1]), t};
    endfunction

    // Scoreboard: every output transfer must match the oldest accepted operand.
    always @(negedge clk) begin
        logic [W+1:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sum", sum, e[W-1:0]);
                check("c_out", c_out, e[W]);
`ifdef CLA_OVF_EN
                check("ovf", ovf, e[W+1]);
`endif
                out_cyc.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                        input logic [W+1:0] e);
        int t;
        a        = va;
        b        = vb;
        c_in     = vc;
        in_valid = 1'b1;
        t        = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                break;
            end
            t++;
            if (t > 50) begin
                check("send_timeout", 0, 1);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        int span;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        rnd_done  = 1'b0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_c_out", c_out, 0);
        check("rst_in_ready", in_ready, 1);
`ifdef CLA_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full ripple through both slices, with the latency observed cycle by cycle.
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, mk(1'b1, 32'h0000_0000, 1'b0));
        @(negedge clk);
        check("t1_not_yet", out_valid, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t1_valid", out_valid, 1);
        check("t1_sum", sum, 32'h0000_0000);
        check("t1_c_out", c_out, 1);
        drain();

        // Back-to-back stream of hand-computed vectors.
        out_cyc.delete();
        send(32'h1234_5678, 32'h8765_4321, 1'b1, mk(1'b0, 32'h9999_999A, 1'b0));
        send(32'h0000_0000, 32'h0000_0000, 1'b0, mk(1'b0, 32'h0000_0000, 1'b0));
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, mk(1'b1, 32'hFFFF_FFFF, 1'b0));
        send(32'h8000_0000, 32'h8000_0000, 1'b0, mk(1'b1, 32'h0000_0000, 1'b1));
        send(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, mk(1'b1, 32'h0000_0000, 1'b0));
        send(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, mk(1'b0, 32'hDEAD_BEF0, 1'b0));
        send(32'h0000_FFFF, 32'h0000_0001, 1'b0, mk(1'b0, 32'h0001_0000, 1'b0));
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, mk(1'b0, 32'h8000_0000, 1'b1));
        drain();
        n = out_cyc.size();
        check("t2_count", n, 8);
        if (n == 8) begin
            span = out_cyc[7] - out_cyc[0];
            check("t2_consecutive", span, 7);
        end

        // Backpressure: output stalled for five cycles while operands keep coming.
        fork
            begin
                send(32'h0000_0001, 32'h0000_0002, 1'b0, mk(1'b0, 32'h0000_0003, 1'b0));
                send(32'h1111_1111, 32'h2222_2222, 1'b0, mk(1'b0, 32'h3333_3333, 1'b0));
                send(32'hFFFF_0000, 32'h0001_0000, 1'b0, mk(1'b1, 32'h0000_0000, 1'b0));
                send(32'h4000_0000, 32'h4000_0000, 1'b0, mk(1'b0, 32'h8000_0000, 1'b1));
            end
            begin
                out_ready = 1'b0;
                repeat (2) @(negedge clk);
                repeat (3) begin
                    @(negedge clk);
                    check("t3_in_ready_low", in_ready, 0);
                    check("t3_out_valid", out_valid, 1);
                    check("t3_sum_held", sum, 32'h0000_0003);
                    check("t3_c_out_held", c_out, 0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two transactions in flight.
        send(32'h1234_5678, 32'h1111_1111, 1'b0, mk(1'b0, 32'h2345_6789, 1'b0));
        send(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, mk(1'b0, 32'hFFFF_FFFF, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_async_valid", out_valid, 0);
        check("t4_async_sum", sum, 0);
        check("t4_async_c_out", c_out, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("t4_no_stale", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(32'h0000_00FF, 32'h0000_0001, 1'b1, mk(1'b0, 32'h0000_0101, 1'b0));
        drain();

        // Signed overflow corner cases.
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, mk(1'b0, 32'h8000_0000, 1'b1));
        send(32'h8000_0000, 32'h8000_0000, 1'b0, mk(1'b1, 32'h0000_0000, 1'b1));
        drain();

        // Short random sweep with random output stalls against an arithmetic reference.
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    ra = $urandom;
                    rb = $urandom;
                    rc = 1'($urandom_range(0, 1));
                    send(ra, rb, rc, model(ra, rb, rc));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
